// File: rtl/mon_exp_core.sv
// mon_exp_core: left-to-right square-and-multiply Montgomery exponentiation
// with a radix-2 bit-serial Montgomery multiplier (WIDTH+1 cycles per product).
// Optional feature macro: MON_EXP_CONVERT_EN -- when defined, a final
// MM(acc, 1) converts the result out of the Montgomery domain.
module mon_exp_core #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned EXP_WIDTH = 1024,
  parameter int unsigned IDX_W     = $clog2(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m_bar,
  input  logic [WIDTH-1:0]     x_bar,
  input  logic [WIDTH-1:0]     n,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [IDX_W-1:0]     e_idx,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     ans
);

  // s needs two headroom bits: s < 2n and t = s + b + n < 4n.
  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
`ifdef MON_EXP_CONVERT_EN
    ST_CONV,
`endif
    ST_FIN
  } state_t;

  // State entered once the last exponent bit has been processed.
`ifdef MON_EXP_CONVERT_EN
  localparam state_t ST_TAIL = ST_CONV;
`else
  localparam state_t ST_TAIL = ST_FIN;
`endif

  state_t               state;
  state_t               state_nxt;

  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     n_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [IDX_W-1:0]     i_reg;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     a_sh;
  logic [SW-1:0]        s;
  logic [CW-1:0]        cnt;

  logic                 accept_c;
  logic                 in_mm_c;
  logic                 last_c;
  logic                 step_c;
  logic [IDX_W-1:0]     idx_clamp_c;
  logic [WIDTH-1:0]     b_c;
  logic [SW-1:0]        t_c;
  logic [SW-1:0]        s_nxt_c;
  logic [WIDTH-1:0]     mm_res_c;

  assign accept_c    = (state == ST_IDLE) && start;
  assign last_c      = (cnt == CW'(WIDTH));
  assign idx_clamp_c = (32'(e_idx) >= EXP_WIDTH) ? IDX_W'(EXP_WIDTH - 1) : e_idx;

  // A Montgomery product is in flight in any of the arithmetic states.
  always_comb begin
    in_mm_c = 1'b0;
    case (state)
      ST_SQR,
`ifdef MON_EXP_CONVERT_EN
      ST_CONV,
`endif
      ST_MUL:  in_mm_c = 1'b1;
      default: in_mm_c = 1'b0;
    endcase
  end

  // Second multiplicand; the first is always acc, streamed LSB-first via a_sh.
  always_comb begin
    b_c = '0;
    case (state)
      ST_SQR:  b_c = acc;
      ST_MUL:  b_c = m_reg;
`ifdef MON_EXP_CONVERT_EN
      ST_CONV: b_c = WIDTH'(1);
`endif
      default: b_c = '0;
    endcase
  end

  // One radix-2 Montgomery iteration plus the final conditional subtraction.
  always_comb begin
    t_c = s + (a_sh[0] ? SW'(b_c) : SW'(0));
    if (t_c[0]) begin
      t_c = t_c + SW'(n_reg);
    end
    s_nxt_c  = t_c >> 1;
    mm_res_c = (s >= SW'(n_reg)) ? WIDTH'(s - SW'(n_reg)) : WIDTH'(s);
  end

  // Next-state logic; step_c marks the exponent-bit step decision.
  always_comb begin
    state_nxt = state;
    step_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SQR;
        end
      end
      ST_SQR: begin
        if (last_c) begin
          if (e_reg[i_reg]) begin
            state_nxt = ST_MUL;
          end else begin
            step_c    = 1'b1;
            state_nxt = (i_reg == '0) ? ST_TAIL : ST_SQR;
          end
        end
      end
      ST_MUL: begin
        if (last_c) begin
          step_c    = 1'b1;
          state_nxt = (i_reg == '0) ? ST_TAIL : ST_SQR;
        end
      end
`ifdef MON_EXP_CONVERT_EN
      ST_CONV: begin
        if (last_c) begin
          state_nxt = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand latch, multiplier datapath and exponent bit pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
      n_reg <= '0;
      e_reg <= '0;
      i_reg <= '0;
      acc   <= '0;
      a_sh  <= '0;
      s     <= '0;
      cnt   <= '0;
    end else if (accept_c) begin
      m_reg <= m_bar;
      n_reg <= n;
      e_reg <= e;
      i_reg <= idx_clamp_c;
      acc   <= x_bar;
      a_sh  <= x_bar;
      s     <= '0;
      cnt   <= '0;
    end else if (in_mm_c) begin
      if (last_c) begin
        acc  <= mm_res_c;
        a_sh <= mm_res_c;
        s    <= '0;
        cnt  <= '0;
        if (step_c && (i_reg != '0)) begin
          i_reg <= i_reg - IDX_W'(1);
        end
      end else begin
        s    <= s_nxt_c;
        a_sh <= a_sh >> 1;
        cnt  <= cnt + CW'(1);
      end
    end
  end

  // Handshake outputs and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      ans  <= '0;
    end else begin
      done <= (state == ST_FIN);
      if (accept_c) begin
        busy <= 1'b1;
      end else if (state == ST_FIN) begin
        busy <= 1'b0;
      end
      if (state == ST_FIN) begin
        ans <= acc;
      end
    end
  end

endmodule

// File: tb/tb_mon_exp_core.sv
// Directed bench for mon_exp_core at WIDTH=10, n=589 (R=1024).
// Expected values follow MON_EXP_CONVERT_EN: normal domain when defined,
// Montgomery domain (value*1024 mod 589) otherwise.
module tb_mon_exp_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] m_bar;
  logic [9:0] x_bar;
  logic [9:0] n;
  logic [15:0] e;
  logic [3:0] e_idx;
  logic       busy;
  logic       done;
  logic [9:0] ans;

  int checks = 0;
  int errors = 0;
  int lat;
  int done_cnt;

`ifdef MON_EXP_CONVERT_EN
  localparam int C_OPS = 1;
  localparam int ANS_A   = 311;  // 199^300 mod 589
  localparam int ANS_Z   = 1;    // x^0
  localparam int ANS_ONE = 199;  // 199^1
`else
  localparam int C_OPS = 0;
  localparam int ANS_A   = 404;  // 311*1024 mod 589
  localparam int ANS_Z   = 435;  // 1024 mod 589
  localparam int ANS_ONE = 571;  // 199*1024 mod 589
`endif
  // ops = (e_idx+1) + popcount + C, each op 11 cycles, plus the FIN cycle
  localparam int LAT_A   = (9 + 4 + C_OPS) * 11 + 1;
  localparam int LAT_Z   = (1 + 0 + C_OPS) * 11 + 1;
  localparam int LAT_ONE = (1 + 1 + C_OPS) * 11 + 1;
  localparam int LAT_PAD = (13 + 4 + C_OPS) * 11 + 1;

  mon_exp_core #(
    .WIDTH    (10),
    .EXP_WIDTH(16),
    .IDX_W    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .m_bar(m_bar),
    .x_bar(x_bar),
    .n    (n),
    .e    (e),
    .e_idx(e_idx),
    .busy (busy),
    .done (done),
    .ans  (ans)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen; gives up after 2000 edges.
  task automatic wait_done(output int l);
    l = 0;
    while (done !== 1'b1 && l < 2000) begin
      tick();
      l++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    m_bar = 10'd571;
    x_bar = 10'd435;
    n     = 10'd589;
    e     = 16'd300;
    e_idx = 4'd8;

    // Reset values
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ans",  32'(ans),  32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Main scenario: 199^300 mod 589
    pulse_start();
    chk("a_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("a_lat",  32'(lat),  32'(LAT_A));
    chk("a_ans",  32'(ans),  32'(ANS_A));
    chk("a_busy_at_done", 32'(busy), 32'd0);

    // Back-to-back: start on the done cycle
    pulse_start();
    chk("b2b_done_low", 32'(done), 32'd0);
    chk("b2b_busy",     32'(busy), 32'd1);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'(LAT_A));
    chk("b2b_ans", 32'(ans), 32'(ANS_A));
    tick();
    chk("b2b_done_pulse", 32'(done), 32'd0);
    repeat (3) tick();
    chk("b2b_ans_held", 32'(ans), 32'(ANS_A));

    // Start while busy with corrupted inputs is ignored
    pulse_start();
    repeat (49) tick();
    start = 1'b1;
    n     = 10'd0;
    m_bar = 10'd0;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("ign_lat", 32'(lat + 50), 32'(LAT_A));
    chk("ign_ans", 32'(ans), 32'(ANS_A));
    n     = 10'd589;
    m_bar = 10'd571;
    tick();

    // Reset mid-operation
    pulse_start();
    repeat (60) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ans",  32'(ans),  32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    done_cnt = 0;
    repeat (200) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_done(lat);
    chk("restart_lat", 32'(lat), 32'(LAT_A));
    chk("restart_ans", 32'(ans), 32'(ANS_A));
    tick();

    // e = 0, e_idx = 0
    e     = 16'd0;
    e_idx = 4'd0;
    pulse_start();
    wait_done(lat);
    chk("e0_lat", 32'(lat), 32'(LAT_Z));
    chk("e0_ans", 32'(ans), 32'(ANS_Z));
    tick();

    // e = 1, e_idx = 0
    e     = 16'd1;
    e_idx = 4'd0;
    pulse_start();
    wait_done(lat);
    chk("e1_lat", 32'(lat), 32'(LAT_ONE));
    chk("e1_ans", 32'(ans), 32'(ANS_ONE));
    tick();

    // Leading zero exponent bits only add squarings of one
    e     = 16'd300;
    e_idx = 4'd12;
    pulse_start();
    wait_done(lat);
    chk("pad_lat", 32'(lat), 32'(LAT_PAD));
    chk("pad_ans", 32'(ans), 32'(ANS_A));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
